instr_mem_arbiter: RTL and testbench

INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

---
 rtl/instr_mem_arbiter_pkg.sv | 18 +
 rtl/instr_mem_arbiter_tag_pipe.sv | 31 +++
 rtl/instr_mem_arbiter.sv | 93 +++++++++
 tb/tb_instr_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter: CPU ids and
// the return tag that travels alongside each outstanding memory read.
package instr_mem_arbiter_pkg;

   localparam int unsigned N_CPUS_DEF      = 3;
   localparam int unsigned MEM_LATENCY_DEF = 2;
   localparam int unsigned MAX_CPUS        = 8;
   localparam int unsigned CPU_ID_W        = $clog2(MAX_CPUS);

   // Sized for the largest legal configuration so one tag type serves every build
   typedef logic [CPU_ID_W-1:0] cpu_id_t;

   typedef struct packed {
      logic    valid;
      cpu_id_t id;
   } ret_tag_t;

endpackage

// File: rtl/instr_mem_arbiter_tag_pipe.sv
// fetch_tag_pipe: fixed-depth shift register carrying return tags so each read
// result is routed to the CPU that issued it.
module fetch_tag_pipe
   import instr_mem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = MEM_LATENCY_DEF
) (
   input  logic     clk,
   input  logic     rst,
   input  ret_tag_t i_tag,
   output ret_tag_t o_tag
);

   ret_tag_t r_stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction memory between
// N_CPUS fetch ports; one read per cycle, results returned by tag.
module instr_mem_arbiter
   import instr_mem_arbiter_pkg::*;
#(
   parameter int unsigned N_CPUS      = N_CPUS_DEF,
   parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CPUS-1:0]             cpu_req,
   input  logic [N_CPUS-1:0][ADDR_W-1:0] cpu_addr,
   output logic [N_CPUS-1:0][31:0]       cpu_data,
   output logic [N_CPUS-1:0]             cpu_vld,
   output logic                          mem_rd,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic [31:0]                   mem_data,
   output logic [$clog2(N_CPUS)-1:0]     grant_id
);

   localparam int unsigned ID_W = $clog2(N_CPUS);
   typedef logic [ID_W-1:0] gid_t;

   // First eligible CPU searching upward from last+1, wrapping; the loop runs
   // backwards so the earliest candidate in search order is the one kept.
   function automatic gid_t rr_search(input logic [N_CPUS-1:0] elig, input gid_t last);
      gid_t        pick;
      int unsigned idx;
      pick = '0;
      for (int unsigned k = N_CPUS; k >= 1; k--) begin
         idx = (32'(last) + k) % N_CPUS;
         if (elig[gid_t'(idx)]) pick = gid_t'(idx);
      end
      return pick;
   endfunction

   logic [N_CPUS-1:0] r_pending;
   gid_t              r_last_grant;
   logic [N_CPUS-1:0] w_elig;
   logic [N_CPUS-1:0] w_grant_oh;
   gid_t              w_grant;
   logic              w_any;
   ret_tag_t          w_tag_in;
   ret_tag_t          w_tag_out;

   assign w_elig   = cpu_req & ~r_pending;
   assign w_any    = (|w_elig) & ~rst;
   assign w_grant  = rr_search(w_elig, r_last_grant);
   assign mem_rd   = w_any;
   assign mem_addr = cpu_addr[w_grant];
   assign grant_id = w_any ? w_grant : '0;

   always_comb begin
      w_grant_oh = '0;
      if (w_any) w_grant_oh[w_grant] = 1'b1;
   end

   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = w_any;
      w_tag_in.id    = cpu_id_t'(w_grant);
   end

   fetch_tag_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   always_comb begin
      for (int unsigned i = 0; i < N_CPUS; i++) begin
         cpu_vld[i]  = w_tag_out.valid && (w_tag_out.id == cpu_id_t'(i)) && !rst;
         cpu_data[i] = mem_data;
      end
   end

   // Pending clears on the edge ending the return cycle, so a CPU is never
   // re-granted while its old address is still on cpu_addr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending    <= '0;
         r_last_grant <= gid_t'(N_CPUS - 1);
      end else begin
         r_pending <= (r_pending | w_grant_oh) & ~cpu_vld;
         if (w_any) r_last_grant <= w_grant;
      end
   end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: grants checked per cycle against hand
// vectors, returns checked by a queue-based scoreboard and memory model.
module tb_instr_mem_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned ML = 2;
   localparam int unsigned AW = 32;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N-1:0]          cpu_req;
   logic [N-1:0][AW-1:0]  cpu_addr;
   logic [N-1:0][31:0]    cpu_data;
   logic [N-1:0]          cpu_vld;
   logic                  mem_rd;
   logic [AW-1:0]         mem_addr;
   logic [31:0]           mem_data;
   logic [1:0]            grant_id;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      int unsigned due;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int unsigned   cyc      = 0;
   logic [AW-1:0] pc [N];
   logic [N-1:0]  vld_last = '0;
   logic [AW-1:0] mem_pipe     [ML];
   logic          mem_pipe_vld [ML];

   instr_mem_arbiter #(
      .N_CPUS      (N),
      .MEM_LATENCY (ML),
      .ADDR_W      (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_req  (cpu_req),
      .cpu_addr (cpu_addr),
      .cpu_data (cpu_data),
      .cpu_vld  (cpu_vld),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // Memory model: data appears exactly ML cycles after the read strobe
   always @(posedge clk) begin
      mem_pipe[0]     <= mem_addr;
      mem_pipe_vld[0] <= mem_rd;
      for (int i = 1; i < ML; i++) begin
         mem_pipe[i]     <= mem_pipe[i-1];
         mem_pipe_vld[i] <= mem_pipe_vld[i-1];
      end
   end

   assign mem_data = mem_pipe_vld[ML-1] ? mem_fn(mem_pipe[ML-1]) : 32'hBAD0_BAD0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every cpu_vld pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cpu_vld != '0) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_vld: got cpu_vld=0x%0h expected none (cycle %0d)",
                        cpu_vld, cyc);
            end else begin
               e = sb_q.pop_front();
               check("vld_onehot", 64'(cpu_vld), 64'(1) << e.id);
               check("vld_cycle", 64'(cyc), 64'(e.due));
               check("vld_data", 64'(cpu_data[e.id]), 64'(e.data));
            end
         end
      end
   end

   // One cycle of stimulus; inputs change 1ns after the edge, outputs compared
   // at the falling edge. CPUs advance their PC after each cpu_vld.
   task automatic run_cycle(input logic [N-1:0] req, input logic exp_rd,
                            input logic [1:0] exp_gid, input logic [AW-1:0] exp_addr,
                            input bit expect_ret);
      for (int i = 0; i < N; i++) if (vld_last[i]) pc[i] = pc[i] + 1;
      vld_last = '0;
      cpu_req  = req;
      for (int i = 0; i < N; i++) cpu_addr[i] = pc[i];
      @(negedge clk);
      check("mem_rd", 64'(mem_rd), 64'(exp_rd));
      check("grant_id", 64'(grant_id), 64'(exp_rd ? exp_gid : 2'd0));
      if (exp_rd) begin
         check("mem_addr", 64'(mem_addr), 64'(exp_addr));
         if (expect_ret) sb_q.push_back('{id: exp_gid, data: mem_fn(exp_addr), due: cyc + ML});
      end
      vld_last = cpu_vld;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle('0, 1'b0, 2'd0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      cpu_req = '1;
      @(negedge clk);
      check("rst_mem_rd", 64'(mem_rd), 64'(0));
      check("rst_grant_id", 64'(grant_id), 64'(0));
      check("rst_cpu_vld", 64'(cpu_vld), 64'(0));
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cpu_req  = '0;
      vld_last = '0;
   endtask

   task automatic check_drained(input string name);
      check(name, 64'(sb_q.size()), 64'(0));
   endtask

   initial begin
      cpu_req  = '0;
      cpu_addr = '0;
      for (int i = 0; i < N; i++) pc[i] = '0;
      do_reset();

      // Single requester: grant, return two cycles later, next grant after
      pc[1] = 32'h10;
      run_cycle(3'b010, 1'b1, 2'd1, 32'h10, 1'b1);
      run_cycle(3'b010, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b010, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b010, 1'b1, 2'd1, 32'h11, 1'b1);
      idle(3);
      check_drained("drain_single");

      // All three requesting: 0,1,2,0,1,2,... with mem_rd every cycle
      do_reset();
      pc[0] = 32'h100; pc[1] = 32'h200; pc[2] = 32'h300;
      run_cycle(3'b111, 1'b1, 2'd0, 32'h100, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd1, 32'h200, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd2, 32'h300, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd0, 32'h101, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd1, 32'h201, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd2, 32'h301, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd0, 32'h102, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd1, 32'h202, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd2, 32'h302, 1'b1);
      idle(3);
      check_drained("drain_all");

      // CPU1 idle: it is skipped, grants alternate 0,2
      do_reset();
      pc[0] = 32'h400; pc[1] = 32'h500; pc[2] = 32'h600;
      run_cycle(3'b101, 1'b1, 2'd0, 32'h400, 1'b1);
      run_cycle(3'b101, 1'b1, 2'd2, 32'h600, 1'b1);
      run_cycle(3'b101, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b101, 1'b1, 2'd0, 32'h401, 1'b1);
      run_cycle(3'b101, 1'b1, 2'd2, 32'h601, 1'b1);
      run_cycle(3'b101, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b101, 1'b1, 2'd0, 32'h402, 1'b1);
      run_cycle(3'b101, 1'b1, 2'd2, 32'h602, 1'b1);
      idle(3);
      check_drained("drain_skip");

      // Reset with two fetches in flight: both discarded, CPU0 first afterwards
      do_reset();
      pc[0] = 32'h700; pc[1] = 32'h800; pc[2] = 32'h900;
      run_cycle(3'b111, 1'b1, 2'd0, 32'h700, 1'b0);
      run_cycle(3'b111, 1'b1, 2'd1, 32'h800, 1'b0);
      do_reset();
      run_cycle(3'b111, 1'b1, 2'd0, 32'h700, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd1, 32'h800, 1'b1);
      run_cycle(3'b111, 1'b1, 2'd2, 32'h900, 1'b1);
      idle(3);
      check_drained("drain_reset");

      // CPU2 drops its request after the grant; the return still arrives and
      // re-raising in the return cycle does not re-grant the stale address
      do_reset();
      pc[2] = 32'hA00;
      run_cycle(3'b100, 1'b1, 2'd2, 32'hA00, 1'b1);
      run_cycle(3'b000, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b100, 1'b0, 2'd0, '0, 1'b0);
      run_cycle(3'b100, 1'b1, 2'd2, 32'hA01, 1'b1);
      idle(3);
      check_drained("drain_drop");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
